reset_sequencer: RTL and testbench



---
 rtl/shell_pkg.sv | 24 ++
 rtl/debounce_sync.sv | 44 ++++
 rtl/reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_reset_sequencer.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/shell_pkg.sv
// Purpose : shared types and width helpers for the reset sequencer slice.
// Latency : n/a (types and constant functions only).
// Backpressure: n/a.
package shell_pkg;

  typedef enum logic [1:0] {
    HOLD,
    RELEASE,
    RUN
  } seq_state_t;

  // Width of the shared stretch/debounce counter: must hold the larger limit.
  function automatic int cnt_width(input int stretch, input int debounce);
    int m;
    m = (stretch > debounce) ? stretch : debounce;
    return $clog2(m + 1);
  endfunction

  // Width of the release stage index.
  function automatic int idx_width(input int n_out);
    return $clog2(n_out + 1);
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Purpose : synchronise the raw active-low board button and debounce it.
// Latency : SYNC_STAGES edges of synchroniser, then DEBOUNCE_CYCLES of stable level.
// Backpressure: none; free-running level filter.
// Ports   : clk, rst (async, active-high), btn_rst_n (raw, async),
//           btn_db (debounced level, 1 = released).
module debounce_sync #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CW              = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_rst_n,
  output logic btn_db
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          db_cnt;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Chain and filter come up in the "released" state so a cold start
      // never sees a spurious press.
      sync_q <= '1;
      db_cnt <= '0;
      btn_db <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_rst_n};
      if (btn_s == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // The differing level has now been seen for DEBOUNCE_CYCLES edges.
        btn_db <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Purpose : assert N_OUT resets together, release them in index order with
//           STRETCH_CYCLES spacing; restart on sw_req or debounced button press.
// Latency : rst_out[i] falls (i+1)*STRETCH_CYCLES edges after the start edge.
// Backpressure: none; triggers are accepted every cycle.
// Ports   : clk, rst (async, active-high), btn_rst_n (raw button, active-low),
//           sw_req (1-cycle request), rst_out[N_OUT], all_released,
//           warm_reset_count[CNT_W] (saturating).
module reset_sequencer
  import shell_pkg::*;
#(
  parameter int N_OUT           = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STRETCH_CYCLES  = 16,
  parameter int CNT_W           = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_rst_n,
  input  logic             sw_req,
  output logic [N_OUT-1:0] rst_out,
  output logic             all_released,
  output logic [CNT_W-1:0] warm_reset_count
);

  localparam int CW = cnt_width(STRETCH_CYCLES, DEBOUNCE_CYCLES);
  localparam int IW = idx_width(N_OUT);

  seq_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d, idx_nxt;
  logic [N_OUT-1:0] rst_out_d;
  logic            all_rel_d;
  logic [CNT_W-1:0] count_d;
  logic            run_en_q;
  logic            btn_db, btn_db_q;
  logic            btn_press, btn_fall, trigger;

  debounce_sync #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CW             (CW)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_rst_n(btn_rst_n),
    .btn_db   (btn_db)
  );

  assign btn_press = ~btn_db;
  assign btn_fall  = btn_db_q & ~btn_db;
  assign trigger   = sw_req | btn_fall;
  assign idx_nxt   = idx_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= HOLD;
      cnt_q            <= '0;
      idx_q            <= '0;
      rst_out          <= '1;
      all_released     <= 1'b0;
      warm_reset_count <= '0;
      run_en_q         <= 1'b0;
      btn_db_q         <= 1'b1;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      rst_out          <= rst_out_d;
      all_released     <= all_rel_d;
      warm_reset_count <= count_d;
      run_en_q         <= 1'b1;
      btn_db_q         <= btn_db;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out;
    all_rel_d = all_released;
    count_d   = warm_reset_count;

    if (trigger) begin
      // A trigger wins in every state, including the first edge after rst.
      state_d   = HOLD;
      cnt_d     = '0;
      idx_d     = '0;
      rst_out_d = '1;
      all_rel_d = 1'b0;
      if (warm_reset_count != '1) begin
        count_d = warm_reset_count + 1'b1;
      end
    end else begin
      case (state_q)
        HOLD: begin
          // The first edge after rst is the timeline origin, like a trigger
          // edge, so counting starts one edge later (run_en_q).
          if (run_en_q && !btn_press) begin
            if (cnt_q == CW'(STRETCH_CYCLES - 1)) begin
              cnt_d        = '0;
              idx_d        = '0;
              rst_out_d[0] = 1'b0;
              if (N_OUT == 1) begin
                state_d   = RUN;
                all_rel_d = 1'b1;
              end else begin
                state_d = RELEASE;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        RELEASE: begin
          // idx_q is the most recently released output.
          if (cnt_q == CW'(STRETCH_CYCLES - 1)) begin
            cnt_d = '0;
            idx_d = idx_nxt;
            for (int i = 0; i < N_OUT; i++) begin
              if (i == int'(idx_nxt)) rst_out_d[i] = 1'b0;
            end
            if (idx_nxt == IW'(N_OUT - 1)) begin
              state_d   = RUN;
              all_rel_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RUN: begin
        end
        default: begin
          state_d = HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int SYNC = 2;
  localparam int D    = 8;
  localparam int S    = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          btn_rst_n;
  logic          sw_req;
  logic [N-1:0]  rst_out;
  logic          all_released;
  logic [CW-1:0] warm_reset_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: m_age counts accepted sequence edges since the
  // start edge; output i is released once m_age reaches (i+1)*S.
  bit m_sync[$];
  bit m_db, m_dbprev, m_started;
  int m_run, m_age, m_cnt;

  reset_sequencer #(
    .N_OUT          (N),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(D),
    .STRETCH_CYCLES (S),
    .CNT_W          (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_rst_n       (btn_rst_n),
    .sw_req          (sw_req),
    .rst_out         (rst_out),
    .all_released    (all_released),
    .warm_reset_count(warm_reset_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic model_reset();
    m_sync.delete();
    for (int i = 0; i < SYNC; i++) m_sync.push_back(1'b1);
    m_db = 1'b1; m_dbprev = 1'b1; m_started = 1'b0;
    m_run = 0; m_age = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    bit trig, bs;
    trig = sw_req || (m_dbprev && !m_db);
    bs = m_sync[0];
    m_sync.push_back(btn_rst_n);
    void'(m_sync.pop_front());
    if (trig) begin
      m_age = 0;
      if (m_cnt < CMAX) m_cnt++;
    end else if (m_started) begin
      if (m_age < S) begin
        if (m_db) m_age++;           // frozen while the button is held
      end else if (m_age < N * S) begin
        m_age++;
      end
    end
    m_started = 1'b1;
    m_dbprev  = m_db;
    if (bs != m_db) begin
      m_run++;
      if (m_run == D) begin
        m_db  = bs;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic tick();
    logic [N-1:0] exp_out;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < N; i++) exp_out[i] = (m_age < (i + 1) * S);
    chk("rst_out", rst_out, exp_out);
    chk("all_released", all_released, (m_age >= N * S));
    chk("warm_reset_count", warm_reset_count, m_cnt);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_sw();
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
  endtask

  // Called just after a tick: reset pulse placed away from any clock edge.
  task automatic async_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("arst_rst_out", rst_out, 3'b111);
    chk("arst_all_released", all_released, 1'b0);
    chk("arst_count", warm_reset_count, 0);
    #2 rst = 1'b0;
  endtask

  initial begin
    int sat_exp [5] = '{1, 2, 3, 3, 3};
    int btn_left;
    bit found;

    rst = 1'b1; btn_rst_n = 1'b1; sw_req = 1'b0;
    model_reset();
    #1;
    chk("reset_rst_out", rst_out, 3'b111);
    chk("reset_all_released", all_released, 1'b0);
    chk("reset_count", warm_reset_count, 0);
    #11 rst = 1'b0;

    // Cold start; directed spot checks on the published timeline.
    tick();                                   // edge 1
    ticks(3); chk("cold_e4_still_held", rst_out, 3'b111);
    tick();   chk("cold_first_release", rst_out, 3'b110);
    ticks(4); chk("cold_second_release", rst_out, 3'b100);
    ticks(4); chk("cold_all_released", all_released, 1'b1);
    ticks(2);

    // Software request in RUN.
    pulse_sw();
    chk("sw_reassert", rst_out, 3'b111);
    chk("sw_count", warm_reset_count, 1);
    ticks(14);

    // Bouncing button: runs of 3 never survive the debounce filter.
    for (int c = 0; c < 30; c++) begin
      btn_rst_n = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    btn_rst_n = 1'b1;
    ticks(12);
    chk("bounce_no_trigger", warm_reset_count, 1);

    // Button held low long enough: trigger, hold until released.
    btn_rst_n = 1'b0;
    ticks(D + SYNC + 8);
    chk("held_outputs", rst_out, 3'b111);
    chk("held_count", warm_reset_count, 2);
    btn_rst_n = 1'b1;
    ticks(D + SYNC + 16);

    // Request mid-RELEASE restarts the whole spacing.
    pulse_sw();
    ticks(S + 2);
    chk("mid_release_state", rst_out, 3'b110);
    pulse_sw();
    chk("mid_release_restart", rst_out, 3'b111);
    ticks(14);

    // sw_req coincident with the debounced button edge: one trigger.
    async_reset();
    ticks(14);
    btn_rst_n = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (!m_db && m_dbprev) found = 1'b1;
      else tick();
    end
    chk("coincide_setup", found, 1'b1);
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    chk("coincide_count", warm_reset_count, 1);
    btn_rst_n = 1'b1;
    ticks(D + SYNC + 16);

    // Saturation of the 2-bit counter.
    async_reset();
    ticks(14);
    for (int k = 0; k < 5; k++) begin
      pulse_sw();
      chk("saturation", warm_reset_count, sat_exp[k]);
      ticks(14);
    end

    // Async reset mid-RELEASE.
    pulse_sw();
    ticks(S + 3);
    async_reset();
    ticks(14);

    // Randomised traffic against the model.
    btn_left = 0;
    for (int c = 0; c < 600; c++) begin
      if (btn_left == 0) begin
        btn_rst_n = ($urandom_range(0, 3) != 0);
        btn_left  = $urandom_range(1, 14);
      end
      btn_left--;
      sw_req = ($urandom_range(0, 24) == 0);
      tick();
      sw_req = 1'b0;
      if ($urandom_range(0, 149) == 0) async_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
